// File: rtl/sofm_mem_arbiter_if.sv
// Requester-side bundle of the SOFM memory arbiter: per-channel level requests in, grant/response out.
// Latency: none (wires only).
// Backpressure: req_grant is the acceptance handshake; an ungranted requester keeps its request asserted.
interface sofm_mem_arbiter_if #(
  parameter int NCH = 2,
  parameter int DW  = 64,
  parameter int AW  = 20
);
  logic [NCH-1:0]    req_read;
  logic [NCH-1:0]    req_write;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*DW-1:0] req_wdata;
  logic [NCH-1:0]    req_grant;
  logic [NCH-1:0]    rsp_valid;
  logic [DW-1:0]     rsp_rdata;

  modport master (
    output req_read, req_write, req_addr, req_wdata,
    input  req_grant, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_read, req_write, req_addr, req_wdata,
    output req_grant, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sofm_mem_arbiter.sv
// N-channel round-robin arbiter onto one single-port SRAM; optional stall counter under SOFM_MEM_STALL_CNT_EN.
// Latency: grant combinational, command on mem_* one cycle later, rsp_valid RD_LAT cycles after mem_read.
// Backpressure: one grant per cycle; losing channels hold their level request until granted.
module sofm_mem_arbiter #(
  parameter int NCH    = 2,
  parameter int DW     = 64,
  parameter int AW     = 20,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  sofm_mem_arbiter_if.slave      bus,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  input  logic [DW-1:0]          mem_rdata,
  output logic [CNT_W-1:0]       n_writeback,
  output logic                   busy
`ifdef SOFM_MEM_STALL_CNT_EN
  ,
  output logic [31:0]            n_stall
`endif
);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [PW-1:0]  ptr;
  logic [NCH-1:0] req_any;
  logic           gnt_vld;
  logic [PW-1:0]  gnt_idx;
  logic           gnt_rd;
  logic           gnt_wr;
  logic [RD_LAT-1:0] tag_vld;
  logic [PW-1:0]     tag_id [RD_LAT];

  // Channel index base+off folded back into 0..NCH-1 (off is at most NCH-1).
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NCH) s = s - NCH;
    return PW'(s);
  endfunction

  assign req_any = bus.req_read | bus.req_write;

  // Scan from the pointer downwards in priority so the nearest requester after ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (req_any[wrap_add(ptr, k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = wrap_add(ptr, k);
      end
    end
  end

  // A read+write request from one channel issues only the read; the write is dropped.
  assign gnt_rd = gnt_vld & bus.req_read[gnt_idx];
  assign gnt_wr = gnt_vld & ~bus.req_read[gnt_idx] & bus.req_write[gnt_idx];

  // One-hot grant decode of the winning channel.
  always_comb begin
    bus.req_grant = '0;
    if (gnt_vld) bus.req_grant[gnt_idx] = 1'b1;
  end

  // Register the granted command onto the backend; address/data hold while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr         <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      n_writeback <= '0;
    end else begin
      mem_read  <= gnt_rd;
      mem_write <= gnt_wr;
      if (gnt_vld) begin
        mem_addr <= bus.req_addr[int'(gnt_idx) * AW +: AW];
        ptr      <= wrap_add(gnt_idx, 1);
      end
      if (gnt_wr) begin
        mem_wdata <= bus.req_wdata[int'(gnt_idx) * DW +: DW];
        if (n_writeback != '1) n_writeback <= n_writeback + CNT_W'(1);
      end
    end
  end

  // Carry the reading channel's id alongside the backend latency, then pulse its rsp_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld       <= '0;
      bus.rsp_valid <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_id[i] <= '0;
    end else begin
      tag_vld[0] <= gnt_rd;
      tag_id[0]  <= gnt_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
      bus.rsp_valid <= '0;
      if (tag_vld[RD_LAT-1]) bus.rsp_valid[tag_id[RD_LAT-1]] <= 1'b1;
    end
  end

  // Backend data arrives in the same cycle its tag emerges; forward it only alongside a valid.
  assign bus.rsp_rdata = (|bus.rsp_valid) ? mem_rdata : '0;
  assign busy          = |tag_vld;

`ifdef SOFM_MEM_STALL_CNT_EN
  // Count cycles where some requester is left waiting; saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_stall <= '0;
    end else if ((|(req_any & ~bus.req_grant)) && (n_stall != '1)) begin
      n_stall <= n_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_sofm_mem_arbiter.sv
// Bench for sofm_mem_arbiter: two instances (RD_LAT=1 with 7-bit counter, RD_LAT=3 with 64-bit counter) share stimulus.
// Latency: cycle-based; outputs sampled 1ns after the rising edge.
// Backpressure: requesters hold requests until the model-predicted grant.
module tb_sofm_mem_arbiter;
  logic clk;
  logic rst;
  logic [1:0]   rd, wr;
  logic [39:0]  addr;
  logic [127:0] wdat;

  logic        m1_rd, m1_wr, busy1, m3_rd, m3_wr, busy3;
  logic [19:0] m1_addr, m3_addr;
  logic [63:0] m1_wdat, m3_wdat, m1_rdat, m3_rdat;
  logic [6:0]  wb1;
  logic [63:0] wb3;
`ifdef SOFM_MEM_STALL_CNT_EN
  logic [31:0] st1, st3;
`endif

  sofm_mem_arbiter_if #(.NCH(2), .DW(64), .AW(20)) if1 ();
  sofm_mem_arbiter_if #(.NCH(2), .DW(64), .AW(20)) if3 ();

  assign if1.req_read = rd;   assign if3.req_read = rd;
  assign if1.req_write = wr;  assign if3.req_write = wr;
  assign if1.req_addr = addr; assign if3.req_addr = addr;
  assign if1.req_wdata = wdat; assign if3.req_wdata = wdat;

  sofm_mem_arbiter #(.NCH(2), .DW(64), .AW(20), .RD_LAT(1), .CNT_W(7)) u1 (
    .clk(clk), .rst(rst), .bus(if1),
    .mem_read(m1_rd), .mem_write(m1_wr), .mem_addr(m1_addr), .mem_wdata(m1_wdat),
    .mem_rdata(m1_rdat), .n_writeback(wb1), .busy(busy1)
`ifdef SOFM_MEM_STALL_CNT_EN
    , .n_stall(st1)
`endif
  );

  sofm_mem_arbiter #(.NCH(2), .DW(64), .AW(20), .RD_LAT(3), .CNT_W(64)) u3 (
    .clk(clk), .rst(rst), .bus(if3),
    .mem_read(m3_rd), .mem_write(m3_wr), .mem_addr(m3_addr), .mem_wdata(m3_wdat),
    .mem_rdata(m3_rdat), .n_writeback(wb3), .busy(busy3)
`ifdef SOFM_MEM_STALL_CNT_EN
    , .n_stall(st3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backend SRAM stand-in: read data is a fixed function of the address.
  function automatic logic [63:0] bdata(input logic [19:0] a);
    return {32'hDEADBEEF, 12'h0, a ^ 20'h00011};
  endfunction

  logic [63:0] p1;
  logic [63:0] p3 [3];
  always @(posedge clk) begin
    p1    <= m1_rd ? bdata(m1_addr) : 64'h0;
    p3[0] <= m3_rd ? bdata(m3_addr) : 64'h0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign m1_rdat = p1;
  assign m3_rdat = p3[2];

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model state: per-cycle record of which channel read what.
  int          cyc, m_ptr, wb, last_rd;
  logic        e_rd, e_wr;
  logic [19:0] e_addr;
  logic [63:0] e_wdat;
  int          rd_ch  [4096];
  logic [63:0] rd_dat [4096];

  task automatic model_reset();
    cyc = 0; m_ptr = 0; wb = 0; last_rd = -100;
    e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wdat = '0;
    for (int i = 0; i < 4096; i++) rd_ch[i] = -1;
  endtask

  task automatic do_reset();
    rst = 1'b0; rd = '0; wr = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
  endtask

  // One cycle: check registered outputs, present requests, check grant, advance.
  task automatic step(input logic [1:0] r, input logic [1:0] w, input logic [39:0] a,
                      input logic [127:0] d, output int g);
    int t1, t3;
    chk("mem_read1", m1_rd, e_rd);   chk("mem_read3", m3_rd, e_rd);
    chk("mem_write1", m1_wr, e_wr);  chk("mem_write3", m3_wr, e_wr);
    if (e_rd || e_wr) begin
      chk("mem_addr1", m1_addr, e_addr); chk("mem_addr3", m3_addr, e_addr);
    end
    if (e_wr) begin
      chk("mem_wdata1", m1_wdat, e_wdat); chk("mem_wdata3", m3_wdat, e_wdat);
    end
    chk("n_wb1", wb1, (wb > 127) ? 127 : wb);
    chk("n_wb3", wb3, wb);
    chk("busy1", busy1, last_rd >= cyc - 1);
    chk("busy3", busy3, last_rd >= cyc - 3);
    t1 = cyc - 2;
    t3 = cyc - 4;
    if (t1 >= 0 && rd_ch[t1] >= 0) begin
      chk("rsp_valid1", if1.rsp_valid, 64'(1) << rd_ch[t1]);
      chk("rsp_rdata1", if1.rsp_rdata, rd_dat[t1]);
    end else chk("rsp_valid1", if1.rsp_valid, 0);
    if (t3 >= 0 && rd_ch[t3] >= 0) begin
      chk("rsp_valid3", if3.rsp_valid, 64'(1) << rd_ch[t3]);
      chk("rsp_rdata3", if3.rsp_rdata, rd_dat[t3]);
    end else chk("rsp_valid3", if3.rsp_valid, 0);

    rd = r; wr = w; addr = a; wdat = d;
    #1;
    g = -1;
    for (int k = 0; k < 2; k++) begin
      int c;
      c = (m_ptr + k) % 2;
      if (g < 0 && (r[c] || w[c])) g = c;
    end
    chk("grant1", if1.req_grant, (g < 0) ? 0 : (64'(1) << g));
    chk("grant3", if3.req_grant, (g < 0) ? 0 : (64'(1) << g));
    e_rd = 1'b0; e_wr = 1'b0;
    if (g >= 0) begin
      m_ptr  = (g + 1) % 2;
      e_addr = a[g*20 +: 20];
      e_rd   = r[g];
      e_wr   = !r[g];
      if (e_wr) begin
        e_wdat = d[g*64 +: 64];
        wb++;
      end
      if (e_rd && cyc < 4096) begin
        rd_ch[cyc]  = g;
        rd_dat[cyc] = bdata(e_addr);
        last_rd     = cyc;
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  typedef struct {
    logic [1:0] rd;
    logic [1:0] wr;
    logic [1:0] gnt;
    logic       mrd;
    logic       mwr;
  } vec_t;
  vec_t tbl [12];

  logic        pend [2];
  logic        pr [2], pw [2];
  logic [19:0] pa [2];
  logic [63:0] pd [2];

  initial begin
    int g;
    tbl[0]  = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{2'b11, 2'b00, 2'b01, 1'b1, 1'b0};
    tbl[2]  = '{2'b11, 2'b00, 2'b10, 1'b1, 1'b0};
    tbl[3]  = '{2'b10, 2'b00, 2'b10, 1'b1, 1'b0};
    tbl[4]  = '{2'b11, 2'b00, 2'b01, 1'b1, 1'b0};
    tbl[5]  = '{2'b00, 2'b01, 2'b01, 1'b0, 1'b1};
    tbl[6]  = '{2'b10, 2'b10, 2'b10, 1'b1, 1'b0};
    tbl[7]  = '{2'b00, 2'b11, 2'b01, 1'b0, 1'b1};
    tbl[8]  = '{2'b00, 2'b11, 2'b10, 1'b0, 1'b1};
    tbl[9]  = '{2'b01, 2'b10, 2'b01, 1'b1, 1'b0};
    tbl[10] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[11] = '{2'b00, 2'b01, 2'b01, 1'b0, 1'b1};

    // Reset state.
    rst = 1'b0; rd = '0; wr = '0; addr = '0; wdat = '0;
    model_reset();
    @(posedge clk); #1;
    chk("rst_mem_read1", m1_rd, 0);   chk("rst_mem_write1", m1_wr, 0);
    chk("rst_mem_addr1", m1_addr, 0); chk("rst_mem_wdata1", m1_wdat, 0);
    chk("rst_n_wb1", wb1, 0);         chk("rst_busy1", busy1, 0);
    chk("rst_rsp_valid1", if1.rsp_valid, 0); chk("rst_rsp_rdata1", if1.rsp_rdata, 0);
    chk("rst_grant1", if1.req_grant, 0);
    chk("rst_mem_read3", m3_rd, 0);   chk("rst_n_wb3", wb3, 0);
    chk("rst_busy3", busy3, 0);       chk("rst_rsp_valid3", if3.rsp_valid, 0);
`ifdef SOFM_MEM_STALL_CNT_EN
    chk("rst_n_stall1", st1, 0);
`endif
    rst = 1'b1;

    // Arbitration table from a fresh pointer.
    for (int i = 0; i < 12; i++) begin
      rd = tbl[i].rd; wr = tbl[i].wr;
      addr = {20'(256 + i), 20'(i)};
      #1;
      chk("tbl_grant1", if1.req_grant, tbl[i].gnt);
      chk("tbl_grant3", if3.req_grant, tbl[i].gnt);
      @(posedge clk); #1;
      chk("tbl_mem_read1", m1_rd, tbl[i].mrd);  chk("tbl_mem_write1", m1_wr, tbl[i].mwr);
      chk("tbl_mem_read3", m3_rd, tbl[i].mrd);  chk("tbl_mem_write3", m3_wr, tbl[i].mwr);
      if (tbl[i].gnt != 2'b00)
        chk("tbl_mem_addr1", m1_addr, tbl[i].gnt[1] ? 20'(256 + i) : 20'(i));
    end
    rd = '0; wr = '0;
    chk("tbl_n_wb1", wb1, 4);
    chk("tbl_n_wb3", wb3, 4);
`ifdef SOFM_MEM_STALL_CNT_EN
    chk("tbl_n_stall1", st1, 6);
    chk("tbl_n_stall3", st3, 6);
`endif

    // Single read, then read+write from one channel.
    do_reset();
    step(2'b01, 2'b00, {20'h0, 20'h00010}, '0, g);
    chk("single_mem_read", m1_rd, 1);
    chk("single_mem_addr", m1_addr, 20'h00010);
    chk("single_busy", busy1, 1);
    step(2'b00, 2'b00, '0, '0, g);
    chk("single_rsp_valid", if1.rsp_valid, 2'b01);
    chk("single_rsp_rdata", if1.rsp_rdata, 64'hDEADBEEF_00000001);
    chk("single_busy_off", busy1, 0);
    repeat (2) step(2'b00, 2'b00, '0, '0, g);
    step(2'b10, 2'b10, {20'h00005, 20'h0}, {64'h55, 64'h0}, g);
    chk("rw_mem_read", m1_rd, 1);
    chk("rw_mem_write", m1_wr, 0);
    chk("rw_n_wb", wb1, 0);
    repeat (4) step(2'b00, 2'b00, '0, '0, g);

    // Four back-to-back reads with RD_LAT=3.
    do_reset();
    repeat (4) step(2'b11, 2'b00, {20'h00005, 20'h00010}, '0, g);
    chk("pipe_rsp0", if3.rsp_valid, 2'b01); chk("pipe_dat0", if3.rsp_rdata, 64'hDEADBEEF_00000001);
    step(2'b00, 2'b00, '0, '0, g);
    chk("pipe_rsp1", if3.rsp_valid, 2'b10); chk("pipe_dat1", if3.rsp_rdata, 64'hDEADBEEF_00000014);
    step(2'b00, 2'b00, '0, '0, g);
    chk("pipe_rsp2", if3.rsp_valid, 2'b01);
    step(2'b00, 2'b00, '0, '0, g);
    chk("pipe_rsp3", if3.rsp_valid, 2'b10);
    repeat (2) step(2'b00, 2'b00, '0, '0, g);

    // Writeback counting and saturation of the 7-bit counter.
    do_reset();
    for (int i = 0; i < 100; i++) step(2'b00, 2'b01, {20'h0, 20'(i)}, {64'h0, 64'(i)}, g);
    chk("wb100_1", wb1, 100);
    chk("wb100_3", wb3, 100);
    for (int i = 0; i < 30; i++) step(2'b00, 2'b01, {20'h0, 20'(i)}, {64'h0, 64'(i)}, g);
    step(2'b00, 2'b00, '0, '0, g);
    chk("wb_sat1", wb1, 127);
    chk("wb_sat3", wb3, 130);

    // Reset while two reads are in flight.
    do_reset();
    step(2'b10, 2'b00, {20'h00003, 20'h0}, '0, g);
    step(2'b01, 2'b00, {20'h0, 20'h00004}, '0, g);
    rst = 1'b0; rd = '0; wr = '0;
    #1;
    chk("mid_busy3", busy3, 0);
    chk("mid_rsp3", if3.rsp_valid, 0);
    chk("mid_rsp1", if1.rsp_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("mid_hold_rsp3", if3.rsp_valid, 0);
      chk("mid_hold_busy3", busy3, 0);
    end
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) step((i == 0) ? 2'b11 : 2'b00, 2'b00, {20'h7, 20'h6}, '0, g);

    // Randomized requesters holding until granted.
    do_reset();
    for (int ch = 0; ch < 2; ch++) begin
      pend[ch] = 1'b0; pr[ch] = 1'b0; pw[ch] = 1'b0; pa[ch] = '0; pd[ch] = '0;
    end
    for (int c = 0; c < 2000; c++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (!pend[ch] && $urandom_range(99) < 60) begin
          int ty;
          ty = int'($urandom_range(3));
          pend[ch] = 1'b1;
          pr[ch] = (ty != 1);
          pw[ch] = (ty == 1) || (ty == 2);
          pa[ch] = 20'($urandom);
          pd[ch] = {$urandom, $urandom};
        end
      end
      step({pend[1] & pr[1], pend[0] & pr[0]}, {pend[1] & pw[1], pend[0] & pw[0]},
           {pa[1], pa[0]}, {pd[1], pd[0]}, g);
      if (g >= 0) pend[g] = 1'b0;
    end
    repeat (5) step(2'b00, 2'b00, '0, '0, g);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
